// File: rtl/fifo_word_packer.sv
// Drains an 8-bit FIFO over its rd_en/rd_ack handshake and packs bytes little-endian into wide words.
// Optional partial-word flush after an idle timeout when PACKER_TIMEOUT_FLUSH_EN is defined.
module fifo_word_packer #(
  parameter int unsigned IN_WIDTH       = 8,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               rd_en,
  input  logic [IN_WIDTH-1:0]                data_out,
  input  logic                               rd_ack,
  input  logic                               empty,
  input  logic                               underflow,
  output logic [IN_WIDTH*BYTES_PER_WORD-1:0] out_data,
  output logic [BYTES_PER_WORD-1:0]          out_keep,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               rd_err
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDLE_W = 8;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BYTES_PER_WORD);

  if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
    $error("fifo_word_packer: parameter out of range");
  end

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] captured_q;
  logic             outstanding_q;
  logic             rst_d_q;
  logic             capture_c;
  logic             last_capture_c;
  logic             flush_c;
  logic             accept_c;

  assign capture_c      = (state_q == FILL) && rd_ack && outstanding_q;
  assign last_capture_c = capture_c && (captured_q == FULL_CNT - CNT_W'(1));
  assign accept_c       = (state_q == HOLD) && out_ready;

`ifdef PACKER_TIMEOUT_FLUSH_EN
  logic [IDLE_W-1:0] idle_q;
  logic              idle_c;

  assign idle_c  = (state_q == FILL) && (captured_q != '0) && !outstanding_q && empty;
  assign flush_c = idle_c && (idle_q >= IDLE_W'(TIMEOUT_CYCLES - 1));

  // Saturating idle counter; any non-idle cycle (capture, data arriving) restarts it
  always_ff @(posedge clk) begin
    if (rst || !idle_c || flush_c) idle_q <= '0;
    else if (idle_q != '1)         idle_q <= idle_q + IDLE_W'(1);
  end
`else
  assign flush_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (last_capture_c || flush_c) state_d = HOLD;
      HOLD:    if (out_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Outputs: rd_en only looks at registered state and empty
  always_comb begin
    rd_en     = 1'b0;
    out_valid = (state_q == HOLD);
    if (!rst && (state_q == FILL) && !empty &&
        ((captured_q + CNT_W'(outstanding_q)) < FULL_CNT))
      rd_en = 1'b1;
  end

  // Lane capture, keep mask and the outstanding-read tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data      <= '0;
      out_keep      <= '0;
      captured_q    <= '0;
      outstanding_q <= 1'b0;
      rst_d_q       <= 1'b1;
    end else begin
      outstanding_q <= rd_en;
      rst_d_q       <= 1'b0;
      if (accept_c) begin
        out_data   <= '0;
        out_keep   <= '0;
        captured_q <= '0;
      end else if (capture_c) begin
        out_data[IN_WIDTH*int'(captured_q) +: IN_WIDTH] <= data_out;
        captured_q <= captured_q + CNT_W'(1);
        if (last_capture_c) out_keep <= {BYTES_PER_WORD{1'b1}};
      end else if (flush_c) begin
        out_keep <= BYTES_PER_WORD'((32'd1 << captured_q) - 32'd1);
      end
    end
  end

  // Sticky protocol error; the first cycle out of reset tolerates a stale ack
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_err <= 1'b0;
    end else if ((outstanding_q && !rd_ack) ||
                 (rd_ack && !outstanding_q && !rst_d_q) ||
                 underflow) begin
      rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: behavioural FIFO model plus word scoreboard.
// Honours PACKER_TIMEOUT_FLUSH_EN the same way as the design.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en;
  logic [7:0]  data_out;
  logic        rd_ack;
  logic        empty;
  logic        underflow = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        rd_err;

  fifo_word_packer #(.IN_WIDTH(8), .BYTES_PER_WORD(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .data_out(data_out), .rd_ack(rd_ack),
    .empty(empty), .underflow(underflow), .out_data(out_data), .out_keep(out_keep),
    .out_valid(out_valid), .out_ready(out_ready), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: pusher owns n_push/mem, reader owns n_pop
  logic [7:0] mem [256];
  int         n_push = 0;
  int         n_pop  = 0;
  logic       withhold  = 1'b0;
  logic       stray_ack = 1'b0;
  logic       fifo_ack  = 1'b0;
  logic [7:0] fifo_dout = 8'h00;

  assign empty    = (n_push == n_pop);
  assign rd_ack   = fifo_ack;
  assign data_out = fifo_dout;

  always @(posedge clk) begin
    if (rd_en && !withhold && (n_push != n_pop)) begin
      fifo_ack  <= 1'b1;
      fifo_dout <= mem[n_pop % 256];
      n_pop     <= n_pop + 1;
    end else begin
      fifo_ack  <= stray_ack;
      fifo_dout <= 8'h00;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    mem[n_push % 256] = b;
    n_push++;
  endtask

  task automatic fifo_flush();
    n_push = n_pop;
  endtask

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
  } exp_t;
  exp_t sb[$];

  task automatic sb_push(input logic [31:0] d, input logic [3:0] k);
    exp_t e;
    e.data = d;
    e.keep = k;
    sb.push_back(e);
  endtask

  // Compare every accepted word against the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_word", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("word_data", 64'(out_data), 64'(e.data));
        check_eq("word_keep", 64'(out_keep), 64'(e.keep));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sb_empty(input string tag, input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      tick(1);
      n++;
    end
    check_eq(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(out_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd_vec;
    logic [7:0] ov_vec;
    logic       seen;

    // Reset values
    tick(2);
    check_eq("rst_rd_en",     64'(rd_en),     64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data",  64'(out_data),  64'd0);
    check_eq("rst_out_keep",  64'(out_keep),  64'd0);
    check_eq("rst_rd_err",    64'(rd_err),    64'd0);
    rst = 1'b0;

    // Back-to-back word with a ready consumer
    out_ready = 1'b1;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    sb_push(32'h44332211, 4'hF);
    rd_vec = '0;
    ov_vec = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd_vec[i] = rd_en;
      ov_vec[i] = out_valid;
    end
    check_eq("t1_rd_en_pattern", 64'(rd_vec), 64'h0F);
    check_eq("t1_valid_pattern", 64'(ov_vec), 64'h20);
    check_eq("t1_rd_err",        64'(rd_err), 64'd0);
    wait_sb_empty("t1_drain", 10);

    // Back-pressure: word held stable, no reads while holding
    tick(1);
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    sb_push(32'h04030201, 4'hF);
    sb_push(32'h08070605, 4'hF);
    wait_valid("t2_first_valid", 20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("t2_hold_valid", 64'(out_valid), 64'd1);
      check_eq("t2_hold_data",  64'(out_data),  64'h04030201);
      check_eq("t2_hold_rd_en", 64'(rd_en),     64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t2_rd_en_after_accept", 64'(rd_en), 64'd1);
    wait_sb_empty("t2_drain", 30);

    // Partial word followed by a stall
    tick(1);
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
`ifdef PACKER_TIMEOUT_FLUSH_EN
    sb_push(32'h00CCBBAA, 4'b0111);
`endif
    tick(10);
    check_eq("t3_no_early_valid", 64'(out_valid), 64'd0);
`ifdef PACKER_TIMEOUT_FLUSH_EN
    wait_sb_empty("t3_flush", 40);
    push_byte(8'hDD);
    sb_push(32'h000000DD, 4'b0001);
`else
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check_eq("t3_no_flush", 64'(seen), 64'd0);
    tick(1);
    push_byte(8'hDD);
    sb_push(32'hDDCCBBAA, 4'hF);
`endif
    wait_sb_empty("t3_drain", 60);

    // Reset mid-word with a read outstanding, plus a stale ack right after reset
    tick(1);
    push_byte(8'hE1); push_byte(8'hE2); push_byte(8'hE3); push_byte(8'hE4);
    tick(3);
    rst       = 1'b1;
    stray_ack = 1'b1;
    tick(1);
    rst       = 1'b0;
    stray_ack = 1'b0;
    fifo_flush();
    @(negedge clk);
    check_eq("t4_valid_after_rst", 64'(out_valid), 64'd0);
    check_eq("t4_data_after_rst",  64'(out_data),  64'd0);
    check_eq("t4_keep_after_rst",  64'(out_keep),  64'd0);
    tick(1);
    check_eq("t4_stale_ack_ignored", 64'(rd_err), 64'd0);
    push_byte(8'h5A); push_byte(8'h5B); push_byte(8'h5C); push_byte(8'h5D);
    sb_push(32'h5D5C5B5A, 4'hF);
    wait_sb_empty("t4_drain", 20);

    // Missing ack sets a sticky error
    tick(1);
    withhold = 1'b1;
    push_byte(8'h77);
    @(negedge clk);
    check_eq("t5_rd_en", 64'(rd_en), 64'd1);
    @(negedge clk);
    check_eq("t5_err_not_yet", 64'(rd_err), 64'd0);
    @(negedge clk);
    check_eq("t5_err_set", 64'(rd_err), 64'd1);
    tick(5);
    check_eq("t5_err_sticky", 64'(rd_err), 64'd1);
    rst      = 1'b1;
    withhold = 1'b0;
    fifo_flush();
    tick(1);
    rst = 1'b0;
    check_eq("t5_err_cleared", 64'(rd_err), 64'd0);

    // Underflow pulse alone sets the error
    tick(2);
    check_eq("t6_err_idle", 64'(rd_err), 64'd0);
    underflow = 1'b1;
    tick(1);
    underflow = 1'b0;
    check_eq("t6_err_underflow", 64'(rd_err), 64'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_eq("t6_err_cleared", 64'(rd_err), 64'd0);

    tick(2);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
